// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit:
// funct3 load/store sizes and the access FSM states.
package mem_access_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mem_access_stage_align.sv
// Byte-lane logic: store enables/replication, alignment check,
// and load extraction with sign/zero extension.
module mem_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_lane,
    input  logic [31:0] i_rdata,
    output logic        o_misalign,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_misalign = 1'b0;
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_misalign = i_lane[0];
                o_be       = 4'b0011 << {i_lane[1], 1'b0};
                o_wdata    = {2{i_wdata[15:0]}};
            end
            2'b10: begin
                // 110 is not a defined load/store width
                o_misalign = (i_lane != 2'b00) | i_funct3[2];
            end
            default: o_misalign = 1'b1;
        endcase
    end

    assign w_shift = i_rdata >> {i_ld_lane, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = i_ld_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_ld_data = '0;
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_ld_data = i_rdata;
            F3_BU:   o_ld_data = {24'd0, w_byte};
            F3_HU:   o_ld_data = {16'd0, w_half};
            default: o_ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access: req/ready transaction to a
// variable-latency memory with pipeline stall and timeout abort.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] Readdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_readdata;
    logic        r_err;
    logic [7:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;

    logic        w_access;
    logic        w_misal;
    logic        w_go;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;

    mem_align u_align (
        .i_funct3    (funct3_i),
        .i_lane      (addr_i[1:0]),
        .i_wdata     (wdata_i),
        .i_ld_funct3 (r_funct3),
        .i_ld_lane   (r_lane),
        .i_rdata     (dmem_rdata_i),
        .o_misalign  (w_misal),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_ld_data   (w_ld_data)
    );

    assign w_access   = MemRead_i | MemWrite_i;
    assign w_go       = (r_state == ST_IDLE) & w_access & ~w_misal;
    assign misalign_o = (r_state == ST_IDLE) & w_access & w_misal;
    assign stall_o    = w_go | (r_state == ST_BUSY);

    assign Readdata_o   = r_readdata;
    assign bus_err_o    = r_err;
    assign dmem_req_o   = r_req;
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_readdata <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_funct3   <= '0;
            r_lane     <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        // a simultaneous read+write is treated as a store
                        r_req    <= 1'b1;
                        r_we     <= MemWrite_i;
                        r_addr   <= {addr_i[31:2], 2'b00};
                        r_be     <= MemWrite_i ? w_be : 4'b1111;
                        r_wdata  <= w_wdata;
                        r_funct3 <= funct3_i;
                        r_lane   <= addr_i[1:0];
                        r_cnt    <= '0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (dmem_ready_i) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_readdata <= w_ld_data;
                        end
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_req      <= 1'b0;
                        r_readdata <= '0;
                        r_err      <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a responding
// memory model and TIMEOUT_CYCLES reduced to 4.
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] Readdata_o;
    logic        stall_o, misalign_o, bus_err_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_rd = 32'd0;

    always #5 clk_i = ~clk_i;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .Readdata_o   (Readdata_o),
        .stall_o      (stall_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ready_i (dmem_ready_i),
        .dmem_rdata_i (dmem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead_i    = 1'b0;
        MemWrite_i   = 1'b0;
        funct3_i     = 3'b000;
        addr_i       = 32'd0;
        wdata_i      = 32'd0;
        dmem_ready_i = 1'b0;
        dmem_rdata_i = 32'd0;
    endtask

    // delay < 0: memory never answers
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata,
                          input int delay, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        int n, stall_cnt, exp_n;
        logic exp_we;
        exp_we = wr;
        exp_n  = (delay < 0) ? 4 : delay + 1;
        if (delay < 0) last_rd = 32'd0;
        else if (!wr) last_rd = exp_rd;
        sb_q.push_back(last_rd);
        MemRead_i  = rd;
        MemWrite_i = wr;
        funct3_i   = f3;
        addr_i     = addr;
        wdata_i    = wd;
        dmem_ready_i = 1'b1;
        dmem_rdata_i = 32'h5555_AAAA;
        #1;
        chk({tag, " idle_stall"}, 32'(stall_o), 32'd1);
        chk({tag, " idle_req"}, 32'(dmem_req_o), 32'd0);
        stall_cnt = 1;
        tick();
        chk({tag, " we"}, 32'(dmem_we_o), 32'(exp_we));
        chk({tag, " addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        chk({tag, " be"}, 32'(dmem_be_o), 32'(exp_be));
        if (wr) chk({tag, " wdata"}, dmem_wdata_o, exp_wd);
        n = 0;
        while (dmem_req_o && n < 20) begin
            if (stall_o) stall_cnt++;
            dmem_ready_i = (delay >= 0) && (n == delay);
            dmem_rdata_i = dmem_ready_i ? rdata : 32'hCCCC_3333;
            tick();
            n++;
        end
        dmem_ready_i = 1'b0;
        chk({tag, " busy_cycles"}, 32'(n), 32'(exp_n));
        chk({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_n + 1));
        chk({tag, " done_stall"}, 32'(stall_o), 32'd0);
        chk({tag, " bus_err"}, 32'(bus_err_o), 32'(delay < 0));
        chk({tag, " readdata"}, Readdata_o, sb_q.pop_front());
        idle_inputs();
        tick();
        chk({tag, " err_clear"}, 32'(bus_err_o), 32'd0);
    endtask

    task automatic bad_access(input string tag, input logic [2:0] f3,
                              input logic [31:0] addr);
        MemRead_i = 1'b1;
        funct3_i  = f3;
        addr_i    = addr;
        #1;
        chk({tag, " misalign"}, 32'(misalign_o), 32'd1);
        chk({tag, " stall"}, 32'(stall_o), 32'd0);
        tick();
        chk({tag, " req"}, 32'(dmem_req_o), 32'd0);
        chk({tag, " readdata"}, Readdata_o, last_rd);
        idle_inputs();
        #1;
        chk({tag, " clear"}, 32'(misalign_o), 32'd0);
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        #12;
        chk("rst_readdata", Readdata_o, 32'd0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_be", 32'(dmem_be_o), 32'd0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        access("lw",    1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 4'hF, 0, 32'hDEADBEEF);
        access("lb",    1, 0, 3'b000, 32'h103, 0, 32'h80123456, 0, 4'hF, 0, 32'hFFFFFF80);
        access("lbu",   1, 0, 3'b100, 32'h103, 0, 32'h80123456, 1, 4'hF, 0, 32'h00000080);
        access("sh",    0, 1, 3'b001, 32'h102, 32'h0000ABCD, 0, 0, 4'hC, 32'hABCDABCD, 0);
        access("lh",    1, 0, 3'b001, 32'h102, 0, 32'h80017FFF, 2, 4'hF, 0, 32'hFFFF8001);
        access("lhu",   1, 0, 3'b101, 32'h000, 0, 32'h8001F00F, 0, 4'hF, 0, 32'h0000F00F);
        access("lb1",   1, 0, 3'b000, 32'h201, 0, 32'h11227F44, 3, 4'hF, 0, 32'h0000007F);
        access("sb",    0, 1, 3'b000, 32'h101, 32'h1234565A, 0, 1, 4'h2, 32'h5A5A5A5A, 0);
        access("sw",    0, 1, 3'b010, 32'h104, 32'h12345678, 0, 0, 4'hF, 32'h12345678, 0);
        access("rw",    1, 1, 3'b010, 32'h108, 32'hCAFEF00D, 32'h01010101, 0, 4'hF,
               32'hCAFEF00D, 0);

        bad_access("lw_mis", 3'b010, 32'h101);
        bad_access("f3_011", 3'b011, 32'h100);
        bad_access("lh_mis", 3'b001, 32'h101);
        bad_access("f3_110", 3'b110, 32'h100);

        access("tmo",   1, 0, 3'b010, 32'h10C, 0, 0, -1, 4'hF, 0, 32'd0);
        access("lw2",   1, 0, 3'b010, 32'h110, 0, 32'h0BADF00D, 0, 4'hF, 0, 32'h0BADF00D);

        MemRead_i = 1'b1;
        funct3_i  = 3'b010;
        addr_i    = 32'h120;
        tick();
        chk("rstb_req", 32'(dmem_req_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("rstb_req_drop", 32'(dmem_req_o), 32'd0);
        chk("rstb_readdata", Readdata_o, 32'd0);
        idle_inputs();
        #2;
        rst_i = 1'b0;
        dmem_ready_i = 1'b1;
        dmem_rdata_i = 32'h77777777;
        tick();
        dmem_ready_i = 1'b0;
        chk("late_readdata", Readdata_o, 32'd0);
        chk("late_req", 32'(dmem_req_o), 32'd0);
        chk("late_stall", 32'(stall_o), 32'd0);
        tick();
        chk("late_readdata2", Readdata_o, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
